// File: rtl/game_sequencer_pkg.sv
// Shared constants for the pipe-scrolling game sequencer: state encodings,
// default geometry and the LFSR step function.
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPlaying = 2'd1,
    StOver    = 2'd2
  } game_state_e;

  localparam int unsigned CoordW      = 11;
  localparam int unsigned XStart      = 640;
  localparam int unsigned PipeSpacing = 320;
  localparam int unsigned XRespawn    = 640;
  localparam int unsigned PipeSpeed   = 2;
  localparam int unsigned GapYMin     = 150;
  localparam int unsigned GapYInit    = 240;
  localparam int unsigned BirdX       = 160;
  localparam int unsigned PipeWidth   = 40;

  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Galois toggle mask for x^8+x^6+x^5+x^4+1, right-shifting form.
  localparam logic [7:0] LfsrMask = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LfsrMask : 8'h00);
  endfunction

endpackage

// File: rtl/game_sequencer_lfsr8.sv
// Free-running 8-bit Galois LFSR; the seed is nonzero and the polynomial
// is primitive, so the all-zero lock-up state is never reached.
module lfsr8
  import game_sequencer_pkg::*;
(
  input  logic       gameClk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;

  always_ff @(posedge gameClk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/game_sequencer.sv
// Game state machine: scrolls two pipes, respawns them with pseudo-random gap
// heights, counts pipes passed by the bird and freezes the field on a hit.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned X_START      = XStart,
  parameter int unsigned PIPE_SPACING = PipeSpacing,
  parameter int unsigned X_RESPAWN    = XRespawn,
  parameter int unsigned PIPE_SPEED   = PipeSpeed,
  parameter int unsigned GAP_Y_MIN    = GapYMin,
  parameter int unsigned GAP_Y_INIT   = GapYInit,
  parameter int unsigned BIRD_X       = BirdX
) (
  input  logic              gameClk,
  input  logic              reset,
  input  logic              start,
  input  logic              hitColumn,
  output logic [CoordW-1:0] Ax,
  output logic [CoordW-1:0] Ay,
  output logic [CoordW-1:0] Bx,
  output logic [CoordW-1:0] By,
  output logic              colReset,
  output logic [1:0]        state,
  output logic [7:0]        score
);

  localparam logic [CoordW-1:0] AxInit  = CoordW'(X_START);
  localparam logic [CoordW-1:0] BxInit  = CoordW'(X_START + PIPE_SPACING);
  localparam logic [CoordW-1:0] YInit   = CoordW'(GAP_Y_INIT);
  localparam logic [CoordW-1:0] XRsp    = CoordW'(X_RESPAWN);
  localparam logic [CoordW-1:0] Speed   = CoordW'(PIPE_SPEED);
  localparam logic [CoordW-1:0] BirdPos = CoordW'(BIRD_X);

  game_state_e       state_q, state_d;
  logic              first_q, first_d;
  logic [CoordW-1:0] ax_q, ax_d, ay_q, ay_d;
  logic [CoordW-1:0] bx_q, bx_d, by_q, by_d;
  logic [7:0]        score_q, score_d;
  logic              col_q, col_d;

  logic [7:0]        lfsr_q;
  logic              unused_lfsr_msb;
  logic [CoordW-1:0] gap_y;
  logic              a_cross, b_cross;
  logic [1:0]        n_cross;
  logic [8:0]        score_sum;

  lfsr8 u_lfsr (
    .gameClk (gameClk),
    .reset   (reset),
    .q       (lfsr_q)
  );

  assign unused_lfsr_msb = lfsr_q[7];
  // One shared sample, so pipes respawning together get the same gap.
  assign gap_y = CoordW'(GAP_Y_MIN) + {{(CoordW-7){1'b0}}, lfsr_q[6:0]};

  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    ax_d      = ax_q;
    ay_d      = ay_q;
    bx_d      = bx_q;
    by_d      = by_q;
    score_d   = score_q;
    a_cross   = 1'b0;
    b_cross   = 1'b0;
    n_cross   = 2'd0;
    score_sum = 9'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPlaying;
          first_d = 1'b1;
        end
      end
      StPlaying: begin
        // The detector output lags by a cycle, so its first value is stale.
        if (hitColumn && !first_q) begin
          state_d = StOver;
        end
      end
      StOver: begin
        if (start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StPlaying) begin
      if (ax_q >= Speed) begin
        ax_d = ax_q - Speed;
      end else begin
        ax_d = XRsp;
        ay_d = gap_y;
      end
      if (bx_q >= Speed) begin
        bx_d = bx_q - Speed;
      end else begin
        bx_d = XRsp;
        by_d = gap_y;
      end
      a_cross   = (ax_q >= BirdPos) && (ax_d < BirdPos);
      b_cross   = (bx_q >= BirdPos) && (bx_d < BirdPos);
      n_cross   = {1'b0, a_cross} + {1'b0, b_cross};
      score_sum = {1'b0, score_q} + {7'd0, n_cross};
      score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
    end else if (state_d == StIdle) begin
      ax_d    = AxInit;
      bx_d    = BxInit;
      ay_d    = YInit;
      by_d    = YInit;
      score_d = 8'd0;
    end

    col_d = (state_d == StIdle);
  end

  always_ff @(posedge gameClk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      first_q <= 1'b0;
      ax_q    <= AxInit;
      bx_q    <= BxInit;
      ay_q    <= YInit;
      by_q    <= YInit;
      score_q <= 8'd0;
      col_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      ax_q    <= ax_d;
      bx_q    <= bx_d;
      ay_q    <= ay_d;
      by_q    <= by_d;
      score_q <= score_d;
      col_q   <= col_d;
    end
  end

  assign Ax       = ax_q;
  assign Ay       = ay_q;
  assign Bx       = bx_q;
  assign By       = by_q;
  assign colReset = col_q;
  assign state    = state_q;
  assign score    = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, hand-written corner
// sequences and random start/hit traffic against a behavioural game model.
module tb_game_sequencer;

  logic        gameClk;
  logic        reset;
  logic        start;
  logic        hitColumn;
  logic [10:0] Ax, Ay, Bx, By;
  logic        colReset;
  logic [1:0]  state;
  logic [7:0]  score;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the game, in plain integers.
  int m_state, m_first, m_ax, m_ay, m_bx, m_by, m_score, m_col, m_lfsr, m_cross_total;

  game_sequencer dut (
    .gameClk   (gameClk),
    .reset     (reset),
    .start     (start),
    .hitColumn (hitColumn),
    .Ax        (Ax),
    .Ay        (Ay),
    .Bx        (Bx),
    .By        (By),
    .colReset  (colReset),
    .state     (state),
    .score     (score)
  );

  initial gameClk = 1'b0;
  always #5 gameClk = ~gameClk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired before the expected event", name);
  endtask

  task automatic model_reset();
    m_state = 0; m_first = 0;
    m_ax = 640; m_bx = 960; m_ay = 240; m_by = 240;
    m_score = 0; m_col = 1; m_lfsr = 'hA5; m_cross_total = 0;
  endtask

  function automatic int galois_step(input int v);
    int r;
    r = v >> 1;
    if ((v & 1) != 0) r = r ^ 'hB8;
    return r;
  endfunction

  task automatic model_step(input logic s, input logic h);
    int ns, nax, nbx, cnt;
    ns = m_state;
    case (m_state)
      0: if (s) ns = 1;
      1: if (h && m_first == 0) ns = 2;
      2: if (s) ns = 0;
      default: ns = 0;
    endcase
    if (m_state == 1) begin
      if (m_ax >= 2) nax = m_ax - 2;
      else begin nax = 640; m_ay = 150 + (m_lfsr % 128); end
      if (m_bx >= 2) nbx = m_bx - 2;
      else begin nbx = 640; m_by = 150 + (m_lfsr % 128); end
      cnt = 0;
      if (m_ax >= 160 && nax < 160) cnt++;
      if (m_bx >= 160 && nbx < 160) cnt++;
      m_cross_total += cnt;
      m_score = (m_score + cnt > 255) ? 255 : m_score + cnt;
      m_ax = nax;
      m_bx = nbx;
    end else if (ns == 0) begin
      m_ax = 640; m_bx = 960; m_ay = 240; m_by = 240; m_score = 0;
    end
    m_first = (m_state == 0 && ns == 1) ? 1 : 0;
    m_state = ns;
    m_col = (ns == 0) ? 1 : 0;
    m_lfsr = galois_step(m_lfsr);
  endtask

  task automatic compare_model();
    check("state", int'(state), m_state);
    check("Ax", int'(Ax), m_ax);
    check("Bx", int'(Bx), m_bx);
    check("Ay", int'(Ay), m_ay);
    check("By", int'(By), m_by);
    check("score", int'(score), m_score);
    check("colReset", int'(colReset), m_col);
  endtask

  task automatic step(input logic s, input logic h);
    start = s;
    hitColumn = h;
    @(posedge gameClk);
    #1;
    model_step(s, h);
    compare_model();
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_Ax"}, int'(Ax), 640);
    check({tag, "_Bx"}, int'(Bx), 960);
    check({tag, "_Ay"}, int'(Ay), 240);
    check({tag, "_By"}, int'(By), 240);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_colReset"}, int'(colReset), 1);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic s;
    logic h;
    int   st;
    int   ax;
    int   bx;
    int   sc;
    int   col;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int  exp_lfsr;
    int  target;
    int  bound;
    logic s, h;

    vecs[0]  = '{1'b1, 1'b0, 1, 640, 960, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1, 638, 958, 0, 0};  // first PLAYING cycle: hit ignored
    vecs[2]  = '{1'b1, 1'b0, 1, 636, 956, 0, 0};  // start ignored while playing
    vecs[3]  = '{1'b0, 1'b1, 2, 634, 954, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 2, 634, 954, 0, 0};  // frozen in OVER
    vecs[5]  = '{1'b1, 1'b0, 0, 640, 960, 0, 1};
    vecs[6]  = '{1'b0, 1'b0, 0, 640, 960, 0, 1};
    vecs[7]  = '{1'b1, 1'b1, 1, 640, 960, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1, 638, 958, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 2, 636, 956, 0, 0};  // start and hit together -> OVER
    vecs[10] = '{1'b1, 1'b0, 0, 640, 960, 0, 1};

    reset = 1'b0;
    start = 1'b0;
    hitColumn = 1'b0;
    model_reset();
    async_reset("por");

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].s, vecs[i].h);
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      check($sformatf("vec%0d_Ax", i), int'(Ax), vecs[i].ax);
      check($sformatf("vec%0d_Bx", i), int'(Bx), vecs[i].bx);
      check($sformatf("vec%0d_score", i), int'(score), vecs[i].sc);
      check($sformatf("vec%0d_colReset", i), int'(colReset), vecs[i].col);
    end

    // Scroll pipe A to the left edge, watching the bird crossing on the way.
    async_reset("pre_scroll");
    step(1'b1, 1'b0);
    bound = 0;
    while (m_ax != 0 && bound < 400) begin
      step(1'b0, 1'b0);
      if (m_ax == 160) check("score_at_ax160", int'(score), 0);
      if (m_ax == 158) check("score_at_ax158", int'(score), 1);
      bound++;
    end
    if (bound >= 400) timeout_fail("ax_to_zero");
    check("ax_at_zero", int'(Ax), 0);
    exp_lfsr = m_lfsr;
    step(1'b0, 1'b0);
    check("ax_respawn", int'(Ax), 640);
    check("ay_respawn", int'(Ay), 150 + (exp_lfsr % 128));
    check("ay_range", (Ay >= 11'd150 && Ay <= 11'd277) ? 1 : 0, 1);

    // Keep playing until the score saturates, then one more crossing.
    bound = 0;
    while (m_score < 255 && bound < 60000) begin
      step(1'b0, 1'b0);
      bound++;
    end
    if (bound >= 60000) timeout_fail("score_to_255");
    check("score_reached_255", int'(score), 255);
    target = m_cross_total + 1;
    bound = 0;
    while (m_cross_total < target && bound < 400) begin
      step(1'b0, 1'b0);
      bound++;
    end
    if (bound >= 400) timeout_fail("extra_crossing");
    check("score_saturated", int'(score), 255);

    // Abort mid-game: nothing may survive the reset.
    async_reset("midgame");
    step(1'b0, 1'b0);

    // Random start/hit traffic.
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 15) == 0);
      h = ($urandom_range(0, 24) == 0);
      step(s, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
